mult_booth: RTL and testbench



---
 rtl/mult_booth.sv | 122 ++++++++++++
 tb/tb_mult_booth.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_booth.sv
// mult_booth -- sequential signed 32x32 Booth multiplier (multdiv unit).
//
// A one-cycle ctrl_MULT pulse in IDLE or DONE samples both operands. The
// product register {ACC, Q, q-1} then takes one add/subtract plus arithmetic
// right shift per clock. The low product word, an overflow flag and a
// one-cycle ready strobe come out registered.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high; clears all state
//   data_operandA   multiplicand, two's complement (sampled at start)
//   data_operandB   multiplier, two's complement (sampled at start)
//   ctrl_MULT       start pulse; ignored while an operation is running
//   data_result     product bits [31:0], held until the next completion
//   data_exception  product does not fit in signed 32 bits
//   data_resultRDY  one-cycle strobe, result valid
//
// Build option: define MULT_RADIX4_EN for radix-4 (modified Booth) recoding.
// That build has 16 steps instead of 32 and gives bit-identical results.
module mult_booth (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

`ifdef MULT_RADIX4_EN
  // Two guard bits so that +/-2M with M = -2^31 still fits the accumulator.
  localparam int         ACC_W    = 34;
  localparam logic [4:0] CNT_LAST = 5'd15;
`else
  // One guard bit so that -M with M = -2^31 still fits the accumulator.
  localparam int         ACC_W    = 33;
  localparam logic [4:0] CNT_LAST = 5'd31;
`endif
  localparam int P_W = ACC_W + 33;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [4:0]              count;
  logic signed [ACC_W-1:0] m;
  logic signed [P_W-1:0]   p;
  logic signed [P_W-1:0]   p_next;

  // One Booth iteration on {ACC, Q, q-1}: recode, add/subtract into ACC,
  // then shift the whole register right with the ACC sign replicated.
  function automatic logic signed [P_W-1:0] booth_step(
    input logic signed [P_W-1:0]   pin,
    input logic signed [ACC_W-1:0] mult
  );
    logic signed [ACC_W-1:0] acc;
    acc = pin[P_W-1 -: ACC_W];
`ifdef MULT_RADIX4_EN
    case (pin[2:0])
      3'b001, 3'b010: acc = acc + mult;
      3'b011:         acc = acc + (mult <<< 1);
      3'b100:         acc = acc - (mult <<< 1);
      3'b101, 3'b110: acc = acc - mult;
      default:        acc = acc;
    endcase
    return $signed({acc, pin[32:0]}) >>> 2;
`else
    case (pin[1:0])
      2'b01:   acc = acc + mult;
      2'b10:   acc = acc - mult;
      default: acc = acc;
    endcase
    return $signed({acc, pin[32:0]}) >>> 1;
`endif
  endfunction

  always_comb begin
    p_next = booth_step(p, m);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 5'd0;
      m              <= '0;
      p              <= '0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctrl_MULT) begin
            m     <= {{(ACC_W-32){data_operandA[31]}}, data_operandA};
            p     <= {{ACC_W{1'b0}}, data_operandB, 1'b0};
            count <= 5'd0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          p     <= p_next;
          count <= count + 5'd1;
          if (count == CNT_LAST) begin
            // Final product {ACC[31:0], Q}; overflow when the high word
            // is not just the sign extension of the low word.
            state          <= DONE;
            data_result    <= p_next[32:1];
            data_exception <= (p_next[64:33] != {32{p_next[32]}});
            data_resultRDY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth -- scoreboard bench for mult_booth.
// The stimulus side pushes {product word, overflow flag, strobe cycle},
// computed with 64-bit integer multiplication, into a queue. The monitor
// pops and compares whenever data_resultRDY is high.
module tb_mult_booth;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  mult_booth dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int due);
    exp_t   e;
    longint prod;
    prod  = longint'($signed(a)) * longint'($signed(b));
    e.res = prod[31:0];
    e.exc = (prod != longint'($signed(prod[31:0])));
    e.due = due;
    return e;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkint(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_rdy: got strobe at cycle %0d expected none", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk32("result", data_result, mon_e.res);
        chk32("exception", {31'd0, data_exception}, {31'd0, mon_e.exc});
        chkint("rdy_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge; the following posedge is the start edge E0.
  // Returns at a negedge with ctrl_MULT low and operands scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    sbq.push_back(model(a, b, cyc + 1 + LAT));
    repeat (hold) @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  logic [31:0] a_tab [10] = '{32'd3, 32'hFFFFFFF9, 32'd6, 32'h80000000, 32'h80000000,
                              32'h00010000, 32'h0000FFFF, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF};
  logic [31:0] b_tab [10] = '{32'd4, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000,
                              32'h00010000, 32'h00010000, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF};

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    chk32("reset_result", data_result, 32'd0);
    chk32("reset_exception", {31'd0, data_exception}, 32'd0);
    chk32("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;

    // Directed products, including the boundary operands.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      start_op(a_tab[i], b_tab[i], 1);
      wait_idle();
    end

    // Randomized: full-range and small signed operands.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      if (i[0]) begin
        a = $urandom;
        b = $urandom;
      end else begin
        a = 32'($urandom_range(0, 400)) - 32'd200;
        b = $urandom;
      end
      @(negedge clock);
      start_op(a, b, 1);
      wait_idle();
    end

    // Start held high for several cycles, then a re-pulse at start+5.
    @(negedge clock);
    start_op(32'h00001234, 32'hFFFF0055, 3);
    repeat (2) @(negedge clock);
    data_operandA = 32'h7FFF0000;
    data_operandB = 32'h00000003;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    wait_idle();

    // Back-to-back: the second start lands in the DONE cycle.
    @(negedge clock);
    start_op(32'd5, 32'd7, 1);
    begin
      int k = 0;
      do begin
        @(negedge clock);
        k++;
      end while (!data_resultRDY && k < 100);
    end
    start_op(32'hFFFFFF00, 32'd9, 1);
    wait_idle();

    // Asynchronous reset mid-operation at start+10.
    @(negedge clock);
    start_op(32'd11, 32'd13, 1);
    repeat (10) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk32("abort_result", data_result, 32'd0);
    chk32("abort_exception", {31'd0, data_exception}, 32'd0);
    chk32("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
    sbq.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // A fresh start after the abort completes normally.
    start_op(32'hFFFFFFF9, 32'd6, 1);
    wait_idle();

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1);
  end

endmodule
